// File: rtl/io_bus_arbiter_if.sv
// Requester handshakes plus memory_io bus bundle for io_bus_arbiter.
// lock_a is present only when IO_ARB_LOCK_EN is defined.
interface io_bus_arbiter_if;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 16;

   logic              req_a;
   logic              req_b;
   logic              we_a;
   logic              we_b;
   logic [ADDR_W-1:0] addr_a;
   logic [ADDR_W-1:0] addr_b;
   logic [DATA_W-1:0] wdata_a;
   logic [DATA_W-1:0] wdata_b;
   logic              ack_a;
   logic              ack_b;
   logic [DATA_W-1:0] rdata_a;
   logic [DATA_W-1:0] rdata_b;
   logic [ADDR_W-1:0] address_io;
   logic [DATA_W-1:0] data_out_io;
   logic [DATA_W-1:0] data_in_io;
   logic [1:0]        control_io;

`ifdef IO_ARB_LOCK_EN
   logic              lock_a;

   modport master (
      input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, lock_a,
      output ack_a, ack_b, rdata_a, rdata_b,
      output address_io, data_out_io, control_io,
      input  data_in_io
   );

   modport slave (
      output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b, lock_a,
      input  ack_a, ack_b, rdata_a, rdata_b,
      input  address_io, data_out_io, control_io,
      output data_in_io
   );
`else
   modport master (
      input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
      output ack_a, ack_b, rdata_a, rdata_b,
      output address_io, data_out_io, control_io,
      input  data_in_io
   );

   modport slave (
      output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
      input  ack_a, ack_b, rdata_a, rdata_b,
      input  address_io, data_out_io, control_io,
      output data_in_io
   );
`endif
endinterface

// File: rtl/io_bus_arbiter.sv
// Round-robin two-port arbiter/sequencer for memory_io: one transaction at a time,
// single-cycle strobes, fixed read latency. Optional A bus lock via IO_ARB_LOCK_EN.
module io_bus_arbiter #(
   parameter int unsigned READ_LATENCY = 2
) (
   input  logic             main_clk,
   input  logic             reset,
   io_bus_arbiter_if.master arb_if
);
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned CNT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

   localparam logic [1:0] CTRL_IDLE  = 2'b00;
   localparam logic [1:0] CTRL_READ  = 2'b01;
   localparam logic [1:0] CTRL_WRITE = 2'b10;
   localparam logic       PORT_A     = 1'b0;
   localparam logic       PORT_B     = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } state_e;

   state_e            state_q, state_d;
   logic              owner_q, owner_d;
   logic              last_q, last_d;
   logic              we_q, we_d;
   logic              locked_q, locked_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
   logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
   logic [1:0]        ctrl_q, ctrl_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ack_a_q, ack_a_d;
   logic              ack_b_q, ack_b_d;

   logic              lock_c;
   logic              lock_hold_c;
   logic              req_b_elig_c;
   logic              grant_c;
   logic              grant_port_c;

`ifdef IO_ARB_LOCK_EN
   assign lock_c = arb_if.lock_a;
`else
   assign lock_c = 1'b0;
`endif

   // Next-state, grant selection and registered-output staging
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      we_d      = we_q;
      locked_d  = locked_q;
      addr_d    = addr_q;
      dout_d    = dout_q;
      rdata_a_d = rdata_a_q;
      rdata_b_d = rdata_b_q;
      cnt_d     = cnt_q;
      ctrl_d    = CTRL_IDLE;
      ack_a_d   = 1'b0;
      ack_b_d   = 1'b0;

      // Lock survives only while lock_a stays high in IDLE; B is masked while it does
      lock_hold_c  = locked_q & lock_c;
      req_b_elig_c = arb_if.req_b & ~lock_hold_c;
      grant_c      = arb_if.req_a | req_b_elig_c;
      grant_port_c = (arb_if.req_a && (!req_b_elig_c || last_q == PORT_B)) ? PORT_A : PORT_B;

      case (state_q)
         ST_IDLE: begin
            locked_d = lock_hold_c;
            if (grant_c) begin
               owner_d = grant_port_c;
               state_d = ST_ISSUE;
               if (grant_port_c == PORT_A) begin
                  we_d   = arb_if.we_a;
                  addr_d = arb_if.addr_a;
                  dout_d = arb_if.wdata_a;
               end else begin
                  we_d   = arb_if.we_b;
                  addr_d = arb_if.addr_b;
                  dout_d = arb_if.wdata_b;
               end
               ctrl_d = we_d ? CTRL_WRITE : CTRL_READ;
            end
         end
         ST_ISSUE: begin
            if (we_q) begin
               state_d = ST_DONE;
               ack_a_d = (owner_q == PORT_A);
               ack_b_d = (owner_q == PORT_B);
            end else begin
               cnt_d   = CNT_LOAD;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_DONE;
               if (owner_q == PORT_A) begin
                  rdata_a_d = arb_if.data_in_io;
                  ack_a_d   = 1'b1;
               end else begin
                  rdata_b_d = arb_if.data_in_io;
                  ack_b_d   = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_DONE: begin
            last_d  = owner_q;
            state_d = ST_IDLE;
            if (owner_q == PORT_A && lock_c) begin
               locked_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge main_clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         owner_q   <= PORT_A;
         last_q    <= PORT_B;
         we_q      <= 1'b0;
         locked_q  <= 1'b0;
         addr_q    <= '0;
         dout_q    <= '0;
         rdata_a_q <= '0;
         rdata_b_q <= '0;
         ctrl_q    <= CTRL_IDLE;
         cnt_q     <= '0;
         ack_a_q   <= 1'b0;
         ack_b_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         we_q      <= we_d;
         locked_q  <= locked_d;
         addr_q    <= addr_d;
         dout_q    <= dout_d;
         rdata_a_q <= rdata_a_d;
         rdata_b_q <= rdata_b_d;
         ctrl_q    <= ctrl_d;
         cnt_q     <= cnt_d;
         ack_a_q   <= ack_a_d;
         ack_b_q   <= ack_b_d;
      end
   end

   assign arb_if.address_io  = addr_q;
   assign arb_if.data_out_io = dout_q;
   assign arb_if.control_io  = ctrl_q;
   assign arb_if.ack_a       = ack_a_q;
   assign arb_if.ack_b       = ack_b_q;
   assign arb_if.rdata_a     = rdata_a_q;
   assign arb_if.rdata_b     = rdata_b_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: directed phases plus random requesters against a
// transaction-level arbitration model and a memory_io slave model.
module tb_io_bus_arbiter;
   localparam int unsigned L = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;

   io_bus_arbiter_if bus ();

   io_bus_arbiter #(.READ_LATENCY(L)) dut (
      .main_clk (clk),
      .reset    (rst),
      .arb_if   (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0, n_fail = 0, cyc = 0;
   // transaction-level model
   int strobe_cyc, ack_cyc, free_at, owner, last_port;
   bit locked, lock_val, lock_rand, rst_next;
   logic m_we;
   logic [31:0] m_addr, e_addr;
   logic [15:0] m_wdata, m_rval, e_dout;
   logic [15:0] e_rdata [2];
   // requester agents
   int mode [2], gap [2], fix_we [2], max_gap [2];
   bit busy [2], granted [2], drop_ok [2];
   logic a_req [2], a_we [2];
   logic [31:0] a_addr [2];
   logic [15:0] a_wdata [2];
   logic [31:0] pool [8];
   // memory_io slave
   logic [15:0] smem [logic [31:0]];
   int rd_due;
   logic [15:0] rd_data;
   // observations of the DUT
   int obs_ack [2], last_ack_cyc [2], n_strobe;
   int log_port [$], log_cyc [$];

   function automatic logic [15:0] mem_rd(input logic [31:0] a);
      if (smem.exists(a)) return smem[a];
      return 16'(a ^ (a >> 16)) ^ 16'hA5C3;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      strobe_cyc = -1; ack_cyc = -1; free_at = cyc + 1;
      last_port = 1; locked = 1'b0; owner = 0;
      e_addr = '0; e_dout = '0; e_rdata[0] = '0; e_rdata[1] = '0;
      rd_due = -1;
      for (int p = 0; p < 2; p++) begin
         busy[p] = 1'b0; granted[p] = 1'b0; a_req[p] = 1'b0; gap[p] = 0;
      end
   endtask

   task automatic check_outputs();
      logic [1:0] ectl;
      ectl = 2'b00;
      if (cyc == strobe_cyc) begin
         ectl   = m_we ? 2'b10 : 2'b01;
         e_addr = m_addr;
         e_dout = m_wdata;
         if (!m_we) m_rval = mem_rd(m_addr);
      end
      if (cyc == ack_cyc && !m_we) e_rdata[owner] = m_rval;
      chk("control_io", 32'(bus.control_io), 32'(ectl));
      chk("address_io", bus.address_io, e_addr);
      chk("data_out_io", 32'(bus.data_out_io), 32'(e_dout));
      chk("ack_a", 32'(bus.ack_a), 32'(cyc == ack_cyc && owner == 0));
      chk("ack_b", 32'(bus.ack_b), 32'(cyc == ack_cyc && owner == 1));
      chk("rdata_a", 32'(bus.rdata_a), 32'(e_rdata[0]));
      chk("rdata_b", 32'(bus.rdata_b), 32'(e_rdata[1]));
      if (bus.control_io !== 2'b00) n_strobe++;
      if (bus.ack_a === 1'b1) begin
         obs_ack[0]++; last_ack_cyc[0] = cyc; log_port.push_back(0); log_cyc.push_back(cyc);
      end
      if (bus.ack_b === 1'b1) begin
         obs_ack[1]++; last_ack_cyc[1] = cyc; log_port.push_back(1); log_cyc.push_back(cyc);
      end
   endtask

   task automatic slave();
      if (bus.control_io == 2'b01) begin
         rd_due  = cyc + int'(L);
         rd_data = mem_rd(bus.address_io);
      end else if (bus.control_io == 2'b10) begin
         smem[bus.address_io] = bus.data_out_io;
      end
   endtask

   task automatic new_txn(input int p);
      a_we[p]    = (fix_we[p] == 2) ? 1'($urandom_range(0, 1)) : 1'(fix_we[p]);
      a_addr[p]  = pool[$urandom_range(0, 7)];
      a_wdata[p] = 16'($urandom);
      a_req[p]   = 1'b1;
      busy[p]    = 1'b1;
   endtask

   task automatic agents();
      int g;
      for (int p = 0; p < 2; p++) begin
         if (cyc == ack_cyc && owner == p) begin
            busy[p] = 1'b0; granted[p] = 1'b0;
            if (mode[p] == 1) begin
               g = $urandom_range(0, max_gap[p]);
               if (g == 0) new_txn(p);
               else begin a_req[p] = 1'b0; gap[p] = g; end
            end else begin
               a_req[p] = 1'b0;
            end
         end else if (!busy[p] && mode[p] == 1) begin
            if (gap[p] > 0) gap[p]--;
            if (gap[p] == 0) new_txn(p);
         end else if (granted[p] && drop_ok[p] && a_req[p] && $urandom_range(0, 3) == 0) begin
            a_req[p] = 1'b0;
         end
      end
   endtask

   task automatic drive();
      rst         = rst_next;
      bus.req_a   = a_req[0];  bus.req_b   = a_req[1];
      bus.we_a    = a_we[0];   bus.we_b    = a_we[1];
      bus.addr_a  = a_addr[0]; bus.addr_b  = a_addr[1];
      bus.wdata_a = a_wdata[0]; bus.wdata_b = a_wdata[1];
      bus.data_in_io = (cyc == rd_due) ? rd_data : 16'($urandom);
      if (lock_rand) lock_val = 1'($urandom_range(0, 1));
`ifdef IO_ARB_LOCK_EN
      bus.lock_a  = lock_val;
`endif
   endtask

   // Arbitration rules applied per transaction: grant when idle, RR on contention
   task automatic model_step();
      bit ra, rb;
      int w;
      if (rst) begin model_reset(); return; end
      if (cyc == ack_cyc) begin
         last_port = owner;
         if (owner == 0 && lock_val) locked = 1'b1;
      end
      if (cyc >= free_at) begin
         ra = a_req[0]; rb = a_req[1];
         if (locked && lock_val) rb = 1'b0;
         else locked = 1'b0;
         w = -1;
         if (ra && (!rb || last_port == 1)) w = 0;
         else if (rb) w = 1;
         if (w >= 0) begin
            owner = w; m_we = a_we[w]; m_addr = a_addr[w]; m_wdata = a_wdata[w];
            strobe_cyc = cyc + 1;
            ack_cyc    = m_we ? cyc + 2 : cyc + 2 + int'(L);
            free_at    = ack_cyc + 1;
            granted[w] = 1'b1;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      #1;
      check_outputs();
      slave();
      agents();
      drive();
      model_step();
   endtask

   task automatic issue(input int p, input logic we, input logic [31:0] addr, input logic [15:0] wd);
      a_we[p] = we; a_addr[p] = addr; a_wdata[p] = wd; a_req[p] = 1'b1; busy[p] = 1'b1;
   endtask

   task automatic wait_ack(input int p, input int base, input int bound);
      for (int i = 0; i < bound && obs_ack[p] == base; i++) step();
      chk(p == 0 ? "ack_a_seen" : "ack_b_seen", 32'(obs_ack[p] - base), 32'd1);
   endtask

   initial begin
      int t0, ba, bb, sb, nlog;
      for (int i = 0; i < 8; i++) pool[i] = $urandom & 32'hFFFF_FFFC;
      for (int p = 0; p < 2; p++) begin
         mode[p] = 0; fix_we[p] = 0; max_gap[p] = 0; drop_ok[p] = 1'b0;
         a_we[p] = 1'b0; a_addr[p] = '0; a_wdata[p] = '0;
         obs_ack[p] = 0; last_ack_cyc[p] = 0;
      end
      n_strobe = 0; lock_val = 1'b0; lock_rand = 1'b0; rst_next = 1'b1; m_we = 1'b0;
      m_addr = '0; m_wdata = '0; m_rval = '0; rd_data = '0;
      model_reset();
      drive();

      repeat (3) step();
      rst_next = 1'b0;
      step();

      // single A write
      ba = obs_ack[0]; bb = obs_ack[1];
      issue(0, 1'b1, 32'h0000_1234, 16'hBEEF); t0 = cyc + 1;
      wait_ack(0, ba, 20);
      chk("wr_latency", 32'(last_ack_cyc[0] - t0), 32'd2);
      chk("wr_no_ack_b", 32'(obs_ack[1] - bb), 32'd0);
      chk("wr_addr_held", bus.address_io, 32'h0000_1234);
      chk("wr_dout_held", 32'(bus.data_out_io), 32'h0000_BEEF);
      step();

      // single B read
      smem[32'h0000_0040] = 16'h5A5A;
      bb = obs_ack[1];
      issue(1, 1'b0, 32'h0000_0040, 16'h0000); t0 = cyc + 1;
      wait_ack(1, bb, 20);
      chk("rd_latency", 32'(last_ack_cyc[1] - t0), 32'(2 + L));
      chk("rd_rdata_b", 32'(bus.rdata_b), 32'h0000_5A5A);
      chk("rd_rdata_a_kept", 32'(bus.rdata_a), 32'd0);
      step();

      // continuous reads on both ports from reset
      rst_next = 1'b1; step(); rst_next = 1'b0;
      log_port.delete(); log_cyc.delete();
      for (int p = 0; p < 2; p++) begin mode[p] = 1; fix_we[p] = 0; max_gap[p] = 0; end
      repeat (40) step();
      mode[0] = 0; mode[1] = 0;
      for (int i = 0; i < 40 && (busy[0] || busy[1]); i++) step();
      nlog = log_port.size();
      chk("alt_count", 32'(nlog >= 6), 32'd1);
      if (nlog > 0) chk("alt_first", 32'(log_port[0]), 32'd0);
      for (int i = 1; i < 6 && i < nlog; i++) begin
         chk("alt_port", 32'(log_port[i]), 32'(1 - log_port[i-1]));
         chk("alt_spacing", 32'(log_cyc[i] - log_cyc[i-1]), 32'(3 + L));
      end

      // reset during WAIT of an A read
      step();
      issue(0, 1'b0, pool[1], 16'h0000); t0 = cyc + 1;
      for (int i = 0; i < 20 && !(strobe_cyc >= t0 && cyc == strobe_cyc + 1); i++) step();
      chk("wait_reached", 32'(cyc == strobe_cyc + 1), 32'd1);
      ba = obs_ack[0];
      rst_next = 1'b1; step(); rst_next = 1'b0; step();
      chk("rst_rdata_a", 32'(bus.rdata_a), 32'd0);
      chk("rst_control", 32'(bus.control_io), 32'd0);
      step();
      chk("rst_no_ack_a", 32'(obs_ack[0] - ba), 32'd0);
      issue(0, 1'b0, pool[1], 16'h0000); t0 = cyc + 1;
      wait_ack(0, ba, 20);
      chk("rst_recover_latency", 32'(last_ack_cyc[0] - t0), 32'(2 + L));
      step();

      // req_a dropped during ISSUE
      ba = obs_ack[0];
      issue(0, 1'b1, pool[2], 16'h1357);
      step();
      a_req[0] = 1'b0;
      sb = n_strobe;
      wait_ack(0, ba, 20);
      chk("drop_single_strobe", 32'(n_strobe - sb), 32'd1);
      repeat (3) step();
      chk("drop_no_restrobe", 32'(n_strobe - sb), 32'd1);

`ifdef IO_ARB_LOCK_EN
      // A locks the bus across three writes while B waits
      lock_val = 1'b1;
      ba = obs_ack[0];
      issue(0, 1'b1, pool[3], 16'h1111);
      wait_ack(0, ba, 20);
      mode[0] = 1; fix_we[0] = 1; max_gap[0] = 0;
      ba = obs_ack[0]; bb = obs_ack[1];
      issue(1, 1'b1, pool[4], 16'h2468);
      for (int i = 0; i < 60 && obs_ack[0] - ba < 3; i++) step();
      chk("lock_a_writes", 32'(obs_ack[0] - ba), 32'd3);
      chk("lock_b_blocked", 32'(obs_ack[1] - bb), 32'd0);
      mode[0] = 0; lock_val = 1'b0;
      wait_ack(1, bb, 30);
      lock_rand = 1'b1;
`endif

      // random traffic
      for (int p = 0; p < 2; p++) begin
         mode[p] = 1; fix_we[p] = 2; max_gap[p] = 3; drop_ok[p] = 1'b1;
      end
      repeat (1500) step();
      mode[0] = 0; mode[1] = 0; lock_rand = 1'b0; lock_val = 1'b0;
      for (int i = 0; i < 100 && (busy[0] || busy[1]); i++) step();
      repeat (3) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/io_bus_arbiter.md
# io_bus_arbiter

Two-port arbiter and sequencer for the `memory_io` bus (`address_io`, `data_out_io`, `data_in_io`, `control_io`). It shares the bus between requester A (`core_main`) and requester B (secondary master: DMA or debug).
- Grants one transaction at a time, round-robin.
- Drives single-cycle read/write strobes.
- Captures read data after a fixed latency.
- Returns a one-cycle `ack` to the owning requester.

## Interface
Parameters:
- `READ_LATENCY`, default 2: cycles from the read strobe cycle to the cycle `data_in_io` is valid; legal range ≥1.

Ports:
- `main_clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_a` / `req_b`  in  1  transaction request from requester A / B.
- `we_a` / `we_b`  in  1  1 = write, 0 = read.
- `addr_a` / `addr_b`  in  32  transaction address.
- `wdata_a` / `wdata_b`  in  16  write data.
- `ack_a` / `ack_b`  out  1  one-cycle completion pulse.
- `rdata_a` / `rdata_b`  out  16  read data; valid with `ack`, held until that port's next read `ack`.
- `lock_a`  in  1  bus lock from A; port present only with `IO_ARB_LOCK_EN`.
- `address_io`  out  32  to `memory_io`.
- `data_out_io`  out  16  write data to `memory_io`.
- `data_in_io`  in  16  read data from `memory_io`.
- `control_io`  out  2  bus strobe encoding:
  - 00 idle
  - 01 read
  - 10 write
  - 11 never driven

## Operation
States: IDLE, ISSUE, WAIT, DONE.
- **IDLE**: sample `req_a`/`req_b`.
  - Exactly one high: grant it.
  - Both high: grant the port not granted last.
  - On grant: latch that port's `we`, `addr`, `wdata` into `address_io`/`data_out_io` registers, record `owner`, go to ISSUE.
- **ISSUE**: `control_io` = 01 (read) or 10 (write) for exactly this cycle.
  - Write: go to DONE.
  - Read: load the latency counter, go to WAIT.
- **WAIT**: count down `READ_LATENCY` cycles. On the cycle `data_in_io` is valid, capture it into `rdata_<owner>` and go to DONE.
- **DONE**: pulse `ack_<owner>`, update `last_grant` = `owner`, go to IDLE.
- `address_io` and `data_out_io` hold their latched value between transactions.
- `control_io` = 00 in every state except ISSUE.
- The non-owner's `ack` and `rdata` are never touched.
- Requesters hold `we`/`addr`/`wdata` stable from `req` until `ack`.
- `req` still high in the cycle after `ack` is a new request.
- `req` dropped before `ack` is ignored: a latched transaction always completes.

## Timing
- Reset values:
  - state IDLE
  - `control_io` = 00, `address_io` = 0, `data_out_io` = 0
  - `ack_a` = `ack_b` = 0, `rdata_a` = `rdata_b` = 0
  - `last_grant` = B, so A wins the first contention
  - lock state cleared
- Request first seen high in IDLE at cycle T:
  - strobe in T+1.
  - Write: `ack` in T+2.
  - Read: `data_in_io` sampled in cycle T+1+`READ_LATENCY`; `ack` and `rdata` valid in T+2+`READ_LATENCY`.
- Back-to-back throughput: one write per 3 cycles; one read per 3+`READ_LATENCY` cycles (IDLE gap included).
- All outputs are registered. No combinational path from `req` to `ack` or `control_io`.
- Reset asserted mid-transaction: next cycle is IDLE with reset values; no `ack` for the aborted transaction; `rdata` cleared.
- Simultaneous requests alternate strictly: A, B, A, B…
- A single continuous requester is granted every transaction.

## Configuration
- `IO_ARB_LOCK_EN` defined:
  - `lock_a` port exists.
  - If `lock_a` = 1 in the DONE cycle of an A-owned transaction, the arbiter enters locked mode: in IDLE only `req_a` is considered and `req_b` waits.
  - Locked mode clears in any IDLE cycle where `lock_a` = 0. Arbitration resumes that same cycle.
  - `last_grant` still updates normally.
- Undefined: no `lock_a` port; pure round-robin.

## Test plan
- Single A write, `addr_a`=0x0000_1234, `wdata_a`=0xBEEF, req at T:
  - `control_io`=10, `address_io`=0x1234, `data_out_io`=0xBEEF in T+1 only.
  - `ack_a` in T+2.
  - `ack_b` stays 0.
- Single B read, `READ_LATENCY`=2, `data_in_io`=0x5A5A in T+3:
  - `control_io`=01 in T+1.
  - `ack_b`=1 and `rdata_b`=0x5A5A in T+4.
  - `rdata_a` unchanged.
- A and B both requesting reads continuously from reset: grants alternate A, B, A, B; each `ack` 5 cycles apart; no overlap.
- `reset` pulsed during WAIT of an A read: no `ack_a`; `control_io`=00; `rdata_a`=0; a new A request completes normally.
- With `IO_ARB_LOCK_EN`, `lock_a`=1 across three A writes while `req_b` is high: B is not granted until the first IDLE with `lock_a`=0, then B is granted that cycle.
- A `req_a` dropped during ISSUE: the transaction still completes and `ack_a` still pulses; no second strobe.
